// File: rtl/store_queue.sv
// Store unit with a DEPTH-entry FIFO store buffer. It formats each store into
// lane-aligned data and byte enables, then drains the queue to memory over a req/ready handshake.
package store_queue_pkg;
    localparam logic [2:0] STR_NOP = 3'd0;
    localparam logic [2:0] SB      = 3'd1;
    localparam logic [2:0] SH      = 3'd2;
    localparam logic [2:0] SW      = 3'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sq_entry_t;
endpackage

module store_queue
    import store_queue_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [31:0]                rs1_val,
    input  logic [31:0]                rs2_val,
    input  logic [31:0]                imm,
    input  logic [2:0]                 store_control,
    output logic                       stall_pc,
    output logic                       ignore_curr_inst,
    output logic                       misalign_exc,
    output logic                       mem_req,
    input  logic                       mem_ready,
    output logic                       mem_rw_mode,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_write_data,
    output logic [3:0]                 mem_byte_en,
    output logic [$clog2(DEPTH+1)-1:0] buf_count,
    output logic                       buf_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      ea;
    logic [1:0]       off;
    logic             is_sb, is_sh, is_sw, is_store;
    logic             misaligned, reject, full, enq, deq;
    sq_entry_t        new_entry, head;
    sq_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    assign ea       = rs1_val + imm;
    assign off      = ea[1:0];
    assign is_sb    = (store_control == SB);
    assign is_sh    = (store_control == SH);
    assign is_sw    = (store_control == SW);
    assign is_store = is_sb | is_sh | is_sw;

    assign misaligned = (is_sh && off[0]) || (is_sw && (off != 2'b00));
    assign reject     = MISALIGN_TRAP && misaligned;
    assign full       = (count == CNT_W'(DEPTH));

    // A dequeue on this edge does not free a slot for the store presented now.
    assign stall_pc = is_store && !reject && full;
    assign enq      = is_store && !reject && !full;
    assign deq      = mem_req && mem_ready;

    // Lane formatting; SH uses only off[1] and SW ignores off, which aligns them when not trapping.
    always_comb begin
        new_entry      = '0;
        new_entry.addr = {ea[31:2], 2'b00};
        if (is_sb) begin
            new_entry.be   = 4'b0001 << off;
            new_entry.data = 32'(rs2_val[7:0]) << {off, 3'b000};
        end else if (is_sh) begin
            if (off[1]) begin
                new_entry.be   = 4'b1100;
                new_entry.data = {rs2_val[15:0], 16'h0000};
            end else begin
                new_entry.be   = 4'b0011;
                new_entry.data = {16'h0000, rs2_val[15:0]};
            end
        end else if (is_sw) begin
            new_entry.be   = 4'b1111;
            new_entry.data = rs2_val;
        end
    end

    assign head           = entries[rd_ptr];
    assign mem_req        = (count != '0);
    assign mem_rw_mode    = ~mem_req;
    assign mem_addr       = mem_req ? head.addr : '0;
    assign mem_write_data = mem_req ? head.data : '0;
    assign mem_byte_en    = mem_req ? head.be   : '0;
    assign buf_count      = count;
    assign buf_empty      = ~mem_req;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            ignore_curr_inst <= 1'b0;
            misalign_exc     <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count            <= count + CNT_W'(enq) - CNT_W'(deq);
            ignore_curr_inst <= stall_pc;
            misalign_exc     <= is_store && reject;
        end
    end

    // Payload storage needs no reset: validity is carried by count.
    always_ff @(posedge i_clk) begin
        if (enq) entries[wr_ptr] <= new_entry;
    end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue. It includes a randomised ready/stall phase
// that checks the drained stores against an issue-order scoreboard.
module tb_store_queue;
    import store_queue_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [2:0]  store_control;
    logic        mem_ready;

    logic        stall_pc, ignore_curr_inst, misalign_exc, mem_req, mem_rw_mode, buf_empty;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_byte_en;
    logic [2:0]  buf_count;

    logic        f_stall_pc, f_ignore, f_misalign, f_mem_req, f_rw_mode, f_empty;
    logic [31:0] f_addr, f_data;
    logic [3:0]  f_be;
    logic [2:0]  f_count;

    int n_assert = 0;
    int n_fail   = 0;

    store_queue #(.DEPTH(4), .MISALIGN_TRAP(1'b1)) u_trap (
        .i_clk(i_clk), .i_rst(i_rst), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .store_control(store_control), .stall_pc(stall_pc), .ignore_curr_inst(ignore_curr_inst),
        .misalign_exc(misalign_exc), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_byte_en(mem_byte_en), .buf_count(buf_count), .buf_empty(buf_empty)
    );

    store_queue #(.DEPTH(4), .MISALIGN_TRAP(1'b0)) u_fix (
        .i_clk(i_clk), .i_rst(i_rst), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .store_control(store_control), .stall_pc(f_stall_pc), .ignore_curr_inst(f_ignore),
        .misalign_exc(f_misalign), .mem_req(f_mem_req), .mem_ready(mem_ready),
        .mem_rw_mode(f_rw_mode), .mem_addr(f_addr), .mem_write_data(f_data),
        .mem_byte_en(f_be), .buf_count(f_count), .buf_empty(f_empty)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] d);
        store_control = c;
        rs1_val       = a;
        imm           = o;
        rs2_val       = d;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
    endtask

    // Independent reference for lane formatting, written as explicit tables.
    function automatic sq_entry_t fmt(input logic [2:0] c, input logic [31:0] ea,
                                      input logic [31:0] d);
        sq_entry_t e;
        e.addr = ea & 32'hFFFF_FFFC;
        e.be   = 4'h0;
        e.data = 32'h0;
        case (c)
            SB: case (ea[1:0])
                2'd0: begin e.be = 4'b0001; e.data = {24'h0, d[7:0]}; end
                2'd1: begin e.be = 4'b0010; e.data = {16'h0, d[7:0], 8'h0}; end
                2'd2: begin e.be = 4'b0100; e.data = {8'h0, d[7:0], 16'h0}; end
                default: begin e.be = 4'b1000; e.data = {d[7:0], 24'h0}; end
            endcase
            SH: if (ea[1]) begin e.be = 4'b1100; e.data = {d[15:0], 16'h0}; end
                else       begin e.be = 4'b0011; e.data = {16'h0, d[15:0]}; end
            SW: begin e.be = 4'b1111; e.data = d; end
            default: ;
        endcase
        return e;
    endfunction

    initial begin
        sq_entry_t   q[$];
        sq_entry_t   e;
        logic [2:0]  r_ctrl;
        logic [31:0] r_rs1, r_imm, r_rs2;
        logic        pending, exp_stall;
        int          accepted, cycles;

        i_rst = 1'b0;
        mem_ready = 1'b0;
        drive(STR_NOP, 0, 0, 0);
        repeat (2) tick();
        chk("rst_stall", 32'(stall_pc), 0);
        chk("rst_ignore", 32'(ignore_curr_inst), 0);
        chk("rst_misalign", 32'(misalign_exc), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_rw", 32'(mem_rw_mode), 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_write_data, 0);
        chk("rst_be", 32'(mem_byte_en), 0);
        chk("rst_count", 32'(buf_count), 0);
        chk("rst_empty", 32'(buf_empty), 1);
        i_rst = 1'b1;
        tick();

        // Reset with stores queued discards them
        drive(SW, 32'h100, 0, 32'h1234_5678); tick();
        drive(SW, 32'h104, 0, 32'h9);         tick();
        drive(STR_NOP, 0, 0, 0);
        chk("q2_count", 32'(buf_count), 2);
        chk("q2_req", 32'(mem_req), 1);
        #2 i_rst = 1'b0;
        #1;
        chk("midrst_count", 32'(buf_count), 0);
        chk("midrst_req", 32'(mem_req), 0);
        chk("midrst_rw", 32'(mem_rw_mode), 1);
        chk("midrst_addr", mem_addr, 0);
        tick();
        i_rst = 1'b1;
        mem_ready = 1'b1;
        tick(); tick();
        chk("postrst_req", 32'(mem_req), 0);
        chk("postrst_empty", 32'(buf_empty), 1);

        // SB into byte lane 3
        mem_ready = 1'b0;
        drive(SB, 32'h1000, 32'd3, 32'hA5);
        #1 chk("sb_req_before", 32'(mem_req), 0);
        tick();
        drive(STR_NOP, 0, 0, 0);
        chk("sb_req", 32'(mem_req), 1);
        chk("sb_rw", 32'(mem_rw_mode), 0);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", 32'(mem_byte_en), 32'h8);
        chk("sb_data", mem_write_data, 32'hA500_0000);
        chk("sb_count", 32'(buf_count), 1);
        mem_ready = 1'b1;
        tick();
        chk("sb_retired", 32'(buf_count), 0);
        chk("sb_req_off", 32'(mem_req), 0);
        chk("sb_addr_off", mem_addr, 0);

        // Fill to DEPTH, fifth store stalls until a slot frees
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(SW, 32'h3000, 32'(4 * i), 32'h1111_0000 + 32'(i));
            #1 chk("fill_nostall", 32'(stall_pc), 0);
            tick();
        end
        drive(STR_NOP, 0, 0, 0);
        #1;
        chk("full_count", 32'(buf_count), 4);
        chk("full_nop_nostall", 32'(stall_pc), 0);
        drive(SW, 32'h3000, 32'd16, 32'h1111_0004);
        #1 chk("full_stall", 32'(stall_pc), 1);
        tick();
        chk("full_ignore", 32'(ignore_curr_inst), 1);
        chk("full_stall_held", 32'(stall_pc), 1);
        chk("full_count_held", 32'(buf_count), 4);
        mem_ready = 1'b1;
        #1;
        chk("full_head_addr", mem_addr, 32'h3000);
        chk("full_deq_nofree", 32'(stall_pc), 1);
        tick();
        chk("full_after_deq", 32'(buf_count), 3);
        chk("full_ignore2", 32'(ignore_curr_inst), 1);
        mem_ready = 1'b0;
        #1 chk("full_stall_drop", 32'(stall_pc), 0);
        tick();
        chk("fifth_accepted", 32'(buf_count), 4);
        chk("ignore_drop", 32'(ignore_curr_inst), 0);
        drive(STR_NOP, 0, 0, 0);
        mem_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("drain_addr", mem_addr, 32'h3000 + 32'(4 * i));
            chk("drain_data", mem_write_data, 32'h1111_0000 + 32'(i));
            tick();
        end
        chk("drain_empty", 32'(buf_empty), 1);

        // Misaligned SW: trapping instance rejects, fixing instance aligns
        do_reset();
        mem_ready = 1'b0;
        drive(SW, 32'h2000, 32'd2, 32'hDEAD_BEEF);
        #1 chk("mis_nostall", 32'(stall_pc), 0);
        tick();
        drive(STR_NOP, 0, 0, 0);
        chk("mis_exc", 32'(misalign_exc), 1);
        chk("mis_count", 32'(buf_count), 0);
        chk("fix_exc", 32'(f_misalign), 0);
        chk("fix_count", 32'(f_count), 1);
        chk("fix_addr", f_addr, 32'h2000);
        chk("fix_be", 32'(f_be), 32'hF);
        chk("fix_data", f_data, 32'hDEAD_BEEF);
        chk("fix_rw", 32'(f_rw_mode), 0);
        chk("fix_req", 32'(f_mem_req), 1);
        chk("fix_empty", 32'(f_empty), 0);
        tick();
        chk("mis_exc_pulse", 32'(misalign_exc), 0);
        chk("fix_stall", 32'(f_stall_pc), 0);
        chk("fix_ignore", 32'(f_ignore), 0);
        do_reset();
        drive(SH, 32'h2000, 32'd3, 32'hCAFE_1234);
        tick();
        drive(STR_NOP, 0, 0, 0);
        chk("mis_sh_exc", 32'(misalign_exc), 1);
        chk("fix_sh_be", 32'(f_be), 32'hC);
        chk("fix_sh_data", f_data, 32'h1234_0000);

        // Steady SH stream with memory always ready
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(SH, 32'h4000, 32'(2 * i), 32'hBEEF_1000 + 32'(i));
            #1 chk("sh_nostall", 32'(stall_pc), 0);
            tick();
            e = fmt(SH, 32'h4000 + 32'(2 * i), 32'hBEEF_1000 + 32'(i));
            chk("sh_count", 32'(buf_count), 1);
            chk("sh_addr", mem_addr, e.addr);
            chk("sh_be", 32'(mem_byte_en), 32'(e.be));
            chk("sh_data", mem_write_data, e.data);
        end
        drive(STR_NOP, 0, 0, 0);
        tick();
        chk("sh_drained", 32'(buf_count), 0);

        // Random readiness against an issue-order scoreboard
        do_reset();
        pending  = 1'b0;
        accepted = 0;
        cycles   = 0;
        r_ctrl = STR_NOP; r_rs1 = 0; r_imm = 0; r_rs2 = 0;
        while (accepted < 200 && cycles < 4000) begin
            if (!pending) begin
                if ($urandom_range(0, 3) == 0) r_ctrl = STR_NOP;
                else r_ctrl = 3'($urandom_range(1, 3));
                r_rs1 = $urandom & 32'hFFFF_FFFC;
                r_rs2 = $urandom;
                case (r_ctrl)
                    SB:      r_imm = 32'($urandom_range(0, 3));
                    SH:      r_imm = 32'(2 * $urandom_range(0, 1));
                    default: r_imm = 32'h0;
                endcase
                pending = (r_ctrl != STR_NOP);
            end
            drive(r_ctrl, r_rs1, r_imm, r_rs2);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            exp_stall = pending && (q.size() == 4);
            chk("rnd_stall", 32'(stall_pc), 32'(exp_stall));
            if (q.size() > 0) begin
                chk("rnd_req", 32'(mem_req), 1);
                chk("rnd_addr", mem_addr, q[0].addr);
                chk("rnd_data", mem_write_data, q[0].data);
                chk("rnd_be", 32'(mem_byte_en), 32'(q[0].be));
            end else begin
                chk("rnd_idle", 32'(mem_req), 0);
            end
            tick();
            if (mem_ready && q.size() > 0) void'(q.pop_front());
            if (pending && !exp_stall) begin
                q.push_back(fmt(r_ctrl, r_rs1 + r_imm, r_rs2));
                accepted++;
                pending = 1'b0;
            end
            cycles++;
        end
        chk("rnd_accepted", 32'(accepted), 200);
        drive(STR_NOP, 0, 0, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            #1;
            chk("rnd_tail_addr", mem_addr, q[0].addr);
            chk("rnd_tail_data", mem_write_data, q[0].data);
            tick();
            void'(q.pop_front());
        end
        chk("rnd_final_count", 32'(buf_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
